conv_accum_tree: RTL

Parametrised, pipelined signed reduction tree that sums `N_IN` packed convolution products, adds a per-output bias, and requantises to `OUT_W` bits. Requantisation is a rounding arithmetic right shift, then optional ReLU, then saturation. It sits between the MAC array and the feature-map writer. A valid/ready handshake gives full back-pressure, and a saturation counter supports quantisation tuning.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/conv_accum_tree_level.sv | 42 ++++
 rtl/conv_accum_tree.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the generic saturating clamp helper.
package cnn_pkg;

   localparam int SAT_CNT_W = 16;
   localparam int SHIFT_W   = 5;

   // Clamp a wide signed value into the signed range of an out_w-bit word.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value, input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (value > hi)
         sat_clamp = hi;
      else if (value < lo)
         sat_clamp = lo;
      else
         sat_clamp = value;
   endfunction

endpackage

// File: rtl/conv_accum_tree_level.sv
// One registered level of the reduction tree: adds adjacent lane pairs, passes an
// odd leftover through, and folds an extra operand into output lane 0.
module tree_level #(
   parameter int N = 2,
   parameter int W = 8,
   localparam int NO = (N + 1) / 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_valid,
   input  logic [N*W-1:0]  in_data,
   input  logic [W-1:0]    in_add,
   output logic            out_valid,
   output logic [NO*W-1:0] out_data
);

   logic [NO*W-1:0] sum_next;

   generate
      for (genvar gi = 0; gi < NO; gi++) begin : g_pair
         logic [W-1:0] extra;
         assign extra = (gi == 0) ? in_add : '0;
         if (2 * gi + 1 < N) begin : g_add
            assign sum_next[gi*W +: W] = in_data[2*gi*W +: W] + in_data[(2*gi+1)*W +: W] + extra;
         end else begin : g_pass
            assign sum_next[gi*W +: W] = in_data[2*gi*W +: W] + extra;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_data  <= sum_next;
      end
   end

endmodule

// File: rtl/conv_accum_tree.sv
// Pipelined signed sum of N_IN products plus bias, requantised by rounding shift,
// optional ReLU and saturation, with a global stall driven by the output handshake.
module conv_accum_tree import cnn_pkg::*; #(
   parameter int N_IN  = 9,
   parameter int IN_W  = 8,
   parameter int OUT_W = 8,
   localparam int LVL   = $clog2(N_IN),
   localparam int ACC_W = IN_W + LVL + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN*IN_W-1:0] in_data,
   input  logic [ACC_W-1:0]     in_bias,
   input  logic [SHIFT_W-1:0]   cfg_shift,
   input  logic                 cfg_relu,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_W-1:0]     out_data,
   output logic                 out_sat,
   output logic [SAT_CNT_W-1:0] sat_count,
   input  logic                 sat_clr
);

   logic                  adv;
   logic                  s0_valid;
   logic [N_IN*IN_W-1:0]  s0_data;
   logic [N_IN*ACC_W-1:0] s0_ext;
   logic [ACC_W-1:0]      bias_pipe [LVL];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Input register plus the bias delay line that lines the bias up with the last level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_valid <= 1'b0;
         s0_data  <= '0;
         for (int k = 0; k < LVL; k++) bias_pipe[k] <= '0;
      end else if (adv) begin
         s0_valid     <= in_valid;
         s0_data      <= in_data;
         bias_pipe[0] <= in_bias;
         for (int k = 1; k < LVL; k++) bias_pipe[k] <= bias_pipe[k-1];
      end
   end

   generate
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_ext
         assign s0_ext[gi*ACC_W +: ACC_W] =
            {{(ACC_W-IN_W){s0_data[gi*IN_W+IN_W-1]}}, s0_data[gi*IN_W +: IN_W]};
      end

      for (genvar gi = 0; gi < LVL; gi++) begin : g_lvl
         localparam int NI = (N_IN + (1 << gi) - 1) >> gi;
         localparam int NO = (NI + 1) / 2;
         logic                vi;
         logic [NI*ACC_W-1:0] di;
         logic [ACC_W-1:0]    ai;
         logic                v;
         logic [NO*ACC_W-1:0] q;

         if (gi == 0) begin : g_first
            assign vi = s0_valid;
            assign di = s0_ext;
         end else begin : g_next
            assign vi = g_lvl[gi-1].v;
            assign di = g_lvl[gi-1].q;
         end

         if (gi == LVL - 1) begin : g_bias
            assign ai = bias_pipe[gi];
         end else begin : g_nobias
            assign ai = '0;
         end

         tree_level #(.N(NI), .W(ACC_W)) u_level (
            .clk      (clk),
            .rst      (rst),
            .en       (adv),
            .in_valid (vi),
            .in_data  (di),
            .in_add   (ai),
            .out_valid(v),
            .out_data (q)
         );
      end
   endgenerate

   logic signed [ACC_W-1:0] tree_sum;
   logic signed [ACC_W:0]   round_bit;
   logic signed [ACC_W:0]   rounded;
   logic signed [ACC_W:0]   shifted;
   logic signed [63:0]      r;
   logic signed [63:0]      clamped;
   logic [OUT_W-1:0]        req_data;
   logic                    req_sat;

   assign tree_sum = g_lvl[LVL-1].q;

   // One extra bit keeps the rounding increment from wrapping the largest sums.
   always_comb begin
      round_bit = '0;
      if (cfg_shift != '0)
         round_bit = (ACC_W+1)'(1) << (cfg_shift - SHIFT_W'(1));
      rounded  = {tree_sum[ACC_W-1], tree_sum} + round_bit;
      shifted  = rounded >>> cfg_shift;
      r        = {{(64-ACC_W-1){shifted[ACC_W]}}, shifted};
      if (cfg_relu && r < 0)
         r = '0;
      clamped  = sat_clamp(r, OUT_W);
      req_data = clamped[OUT_W-1:0];
      req_sat  = (clamped != r);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (adv) begin
         out_valid <= g_lvl[LVL-1].v;
         out_data  <= req_data;
         out_sat   <= req_sat;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sat_count <= '0;
      else if (sat_clr)
         sat_count <= '0;
      else if (out_valid && out_ready && out_sat && sat_count != '1)
         sat_count <= sat_count + SAT_CNT_W'(1);
   end

   shift_range_a: assert property (@(posedge clk) disable iff (!rst) cfg_shift < SHIFT_W'(ACC_W));

endmodule
